// File: rtl/tag_way_array.sv
// tag_way_array: N-way set-associative tag store with registered lookup,
// per-way valid/dirty, victim selection and an invalidate-all sweep.
//
// Ports:
//   clk, resetn          clock, synchronous active-low reset
//   lk_req/lk_set/lk_tag lookup request (accepted while lk_ready)
//   lk_ready             high when lookups/fills are accepted (not sweeping)
//   rsp_*                registered lookup result, rsp_valid is a 1-cycle pulse
//   fill_*               tag fill into (fill_set, fill_way), sets valid
//   mark_en              set dirty of valid line (fill_set, fill_way)
//   flush_req, busy      start / in-progress flag of the invalidate-all sweep
//
// Optional: define TAG_WAY_ARRAY_DIRTY_EN to store dirty bits; otherwise
// fill_dirty and mark_en are ignored and rsp_victim_dirty is 0.

module tag_way_array #(
    parameter int TAG_WIDTH = 24,
    parameter int SET_BITS  = 3,
    parameter int WAYS      = 4,
    localparam int SETS     = 1 << SET_BITS,
    localparam int WAY_BITS = $clog2(WAYS)
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 lk_req,
    input  logic [SET_BITS-1:0]  lk_set,
    input  logic [TAG_WIDTH-1:0] lk_tag,
    output logic                 lk_ready,
    output logic                 rsp_valid,
    output logic                 rsp_hit,
    output logic [WAY_BITS-1:0]  rsp_way,
    output logic                 rsp_victim_valid,
    output logic                 rsp_victim_dirty,
    output logic [TAG_WIDTH-1:0] rsp_victim_tag,
    input  logic                 fill_en,
    input  logic [SET_BITS-1:0]  fill_set,
    input  logic [WAY_BITS-1:0]  fill_way,
    input  logic [TAG_WIDTH-1:0] fill_tag,
    input  logic                 fill_dirty,
    input  logic                 mark_en,
    input  logic                 flush_req,
    output logic                 busy
);

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t              state, state_nx;
    logic [SET_BITS-1:0] idx, idx_nx;

    logic [TAG_WIDTH-1:0] tags  [SETS][WAYS];
    logic [WAYS-1:0]      valid [SETS];
    logic [WAY_BITS-1:0]  rr    [SETS];

    logic                hit;
    logic [WAY_BITS-1:0] hit_way;
    logic                vic_free;
    logic [WAY_BITS-1:0] vic_way;
    logic                vic_dirty;

    logic do_lk;
    logic do_fill;

    assign lk_ready = (state == IDLE);
    assign busy     = (state == SWEEP);
    assign do_lk    = lk_req & lk_ready;
    assign do_fill  = fill_en & lk_ready;

    // Sweep FSM
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
        end
    end

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        unique case (state)
            IDLE: begin
                if (flush_req) begin
                    state_nx = SWEEP;
                    idx_nx   = '0;
                end
            end
            SWEEP: begin
                idx_nx = idx + SET_BITS'(1);
                if (idx == SET_BITS'(SETS - 1))
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Tags carry no reset; valid gates every use of them.
    always_ff @(posedge clk) begin
        if (resetn && do_fill)
            tags[fill_set][fill_way] <= fill_tag;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int s = 0; s < SETS; s++) begin
                valid[s] <= '0;
                rr[s]    <= '0;
            end
        end else if (state == SWEEP) begin
            valid[idx] <= '0;
            rr[idx]    <= '0;
        end else if (fill_en) begin
            valid[fill_set][fill_way] <= 1'b1;
            // Pointer only advances when the fill consumed the rr victim.
            if (fill_way == rr[fill_set])
                rr[fill_set] <= rr[fill_set] + WAY_BITS'(1);
        end
    end

`ifdef TAG_WAY_ARRAY_DIRTY_EN
    logic [WAYS-1:0] dirty [SETS];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int s = 0; s < SETS; s++)
                dirty[s] <= '0;
        end else if (state == SWEEP) begin
            dirty[idx] <= '0;
        end else if (fill_en) begin
            // A store hit on the line being filled leaves it dirty.
            dirty[fill_set][fill_way] <= fill_dirty | mark_en;
        end else if (mark_en && valid[fill_set][fill_way]) begin
            dirty[fill_set][fill_way] <= 1'b1;
        end
    end

    assign vic_dirty = !vic_free && dirty[lk_set][vic_way];
`else
    logic unused_dirty_in;

    assign unused_dirty_in = fill_dirty ^ mark_en;
    assign vic_dirty       = 1'b0;
`endif

    // Descending scan leaves the lowest matching / lowest invalid way.
    always_comb begin
        hit      = 1'b0;
        hit_way  = '0;
        vic_free = 1'b0;
        vic_way  = rr[lk_set];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid[lk_set][w] && tags[lk_set][w] == lk_tag) begin
                hit     = 1'b1;
                hit_way = WAY_BITS'(w);
            end
            if (!valid[lk_set][w]) begin
                vic_free = 1'b1;
                vic_way  = WAY_BITS'(w);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rsp_valid        <= 1'b0;
            rsp_hit          <= 1'b0;
            rsp_way          <= '0;
            rsp_victim_valid <= 1'b0;
            rsp_victim_dirty <= 1'b0;
            rsp_victim_tag   <= '0;
        end else begin
            rsp_valid <= do_lk;
            if (do_lk) begin
                rsp_hit          <= hit;
                rsp_way          <= hit ? hit_way : vic_way;
                rsp_victim_valid <= !vic_free;
                rsp_victim_dirty <= vic_dirty;
                rsp_victim_tag   <= tags[lk_set][vic_way];
            end
        end
    end

endmodule
